// File: rtl/timestamp_div_pkg.sv
// Shared constants for the timestamp_div output-word decoder: word type
// nibbles, field positions inside a 32-bit FIFO word and FSM state codes.
package timestamp_div_pkg;

    // Type nibbles carried in bits [27:24] of every record word
    localparam logic [3:0] TS_W_LO  = 4'h1;
    localparam logic [3:0] TS_W_MID = 4'h2;
    localparam logic [3:0] TS_W_HI  = 4'h3;

    // Common word fields
    localparam int ID_MSB      = 31;
    localparam int ID_LSB      = 28;
    localparam int TYPE_MSB    = 27;
    localparam int TYPE_LSB    = 24;
    localparam int PAYLOAD_MSB = 23;
    localparam int PAYLOAD_LSB = 0;

    // Word 3 carries the 16-bit ToT above the top timestamp byte
    localparam int TOT_MSB   = 23;
    localparam int TOT_LSB   = 8;
    localparam int TS_HI_MSB = 7;
    localparam int TS_HI_LSB = 0;

    // FSM states: which record word is expected next
    localparam logic [1:0] ST_WAIT3 = 2'd0;
    localparam logic [1:0] ST_WAIT2 = 2'd1;
    localparam logic [1:0] ST_WAIT1 = 2'd2;

endpackage

// File: rtl/timestamp_div_word_decoder_sat_counter8.sv
// 8-bit event counter that sticks at 255; a clear request wins over a
// simultaneous increment.
module sat_counter8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear first, otherwise step unless already saturated
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (inc && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/timestamp_div_word_decoder.sv
// Pops three-word timestamp records from the timestamp_div output FIFO,
// checks ID and word order, and presents each rebuilt 56-bit timestamp plus
// 16-bit ToT on a valid/ready stream. Error events feed saturating counters.
module timestamp_div_word_decoder
    import timestamp_div_pkg::*;
#(
    parameter logic [3:0] IDENTIFIER = 4'b0001,
    parameter bit         CHECK_ID   = 1'b1
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,
    input  logic        FIFO_EMPTY,
    input  logic [31:0] FIFO_DATA,
    output logic        FIFO_READ,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [3:0]  OUT_ID,
    output logic [55:0] OUT_TIMESTAMP,
    output logic [15:0] OUT_TOT,
    input  logic        CLR_CNT,
    output logic [15:0] REC_CNT,
    output logic [7:0]  SEQ_ERR_CNT,
    output logic [7:0]  ID_ERR_CNT
);

    logic [1:0]  state_q,     state_d;
    logic [3:0]  id_q,        id_d;
    logic [15:0] tot_q,       tot_d;
    logic [7:0]  ts_hi_q,     ts_hi_d;
    logic [23:0] ts_mid_q,    ts_mid_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  out_id_q,    out_id_d;
    logic [55:0] out_ts_q,    out_ts_d;
    logic [15:0] out_tot_q,   out_tot_d;
    logic [15:0] rec_cnt_q,   rec_cnt_d;

    logic        stall;
    logic        fifo_read;
    logic [3:0]  w_id;
    logic [3:0]  w_type;
    logic [23:0] w_payload;
    logic        id_ok;
    logic        same_id;
    logic        seq_err;
    logic        id_err;
    logic        emit;

    // Word decode, FSM next state and partial-record capture
    always_comb begin
        stall     = out_valid_q & ~OUT_READY;
        fifo_read = ~FIFO_EMPTY & ~stall & ~BUS_RST;
        w_id      = FIFO_DATA[ID_MSB:ID_LSB];
        w_type    = FIFO_DATA[TYPE_MSB:TYPE_LSB];
        w_payload = FIFO_DATA[PAYLOAD_MSB:PAYLOAD_LSB];
        id_ok     = (CHECK_ID == 1'b0) || (w_id == IDENTIFIER);
        same_id   = (w_id == id_q);

        state_d  = state_q;
        id_d     = id_q;
        tot_d    = tot_q;
        ts_hi_d  = ts_hi_q;
        ts_mid_d = ts_mid_q;
        seq_err  = 1'b0;
        id_err   = 1'b0;
        emit     = 1'b0;

        if (fifo_read) begin
            if (!id_ok) begin
                id_err = 1'b1;
            end else begin
                case (w_type)
                    TS_W_HI: begin
                        // A word 3 always opens a fresh record, even mid-record
                        seq_err = (state_q != ST_WAIT3);
                        id_d    = w_id;
                        tot_d   = FIFO_DATA[TOT_MSB:TOT_LSB];
                        ts_hi_d = FIFO_DATA[TS_HI_MSB:TS_HI_LSB];
                        state_d = ST_WAIT2;
                    end
                    TS_W_MID: begin
                        if ((state_q == ST_WAIT2) && same_id) begin
                            ts_mid_d = w_payload;
                            state_d  = ST_WAIT1;
                        end else begin
                            seq_err = 1'b1;
                            state_d = ST_WAIT3;
                        end
                    end
                    TS_W_LO: begin
                        if ((state_q == ST_WAIT1) && same_id) begin
                            emit = 1'b1;
                        end else begin
                            seq_err = 1'b1;
                        end
                        state_d = ST_WAIT3;
                    end
                    default: begin
                        seq_err = 1'b1;
                        state_d = ST_WAIT3;
                    end
                endcase
            end
        end
    end

    // Output register and record counter; a new record may replace one being accepted
    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_ts_d    = out_ts_q;
        out_tot_d   = out_tot_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_id_d    = id_q;
            out_ts_d    = {ts_hi_q, ts_mid_q, w_payload};
            out_tot_d   = tot_q;
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end

        rec_cnt_d = rec_cnt_q;
        if (CLR_CNT) begin
            rec_cnt_d = 16'd0;
        end else if (emit) begin
            rec_cnt_d = rec_cnt_q + 16'd1;
        end
    end

    // State registers with synchronous reset that drops any partial or pending record
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q     <= ST_WAIT3;
            id_q        <= 4'd0;
            tot_q       <= 16'd0;
            ts_hi_q     <= 8'd0;
            ts_mid_q    <= 24'd0;
            out_valid_q <= 1'b0;
            out_id_q    <= 4'd0;
            out_ts_q    <= 56'd0;
            out_tot_q   <= 16'd0;
            rec_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            tot_q       <= tot_d;
            ts_hi_q     <= ts_hi_d;
            ts_mid_q    <= ts_mid_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_ts_q    <= out_ts_d;
            out_tot_q   <= out_tot_d;
            rec_cnt_q   <= rec_cnt_d;
        end
    end

    sat_counter8 u_seq_err_cnt (
        .clk   (BUS_CLK),
        .rst   (BUS_RST),
        .clr   (CLR_CNT),
        .inc   (seq_err),
        .count (SEQ_ERR_CNT)
    );

    sat_counter8 u_id_err_cnt (
        .clk   (BUS_CLK),
        .rst   (BUS_RST),
        .clr   (CLR_CNT),
        .inc   (id_err),
        .count (ID_ERR_CNT)
    );

    assign FIFO_READ     = fifo_read;
    assign OUT_VALID     = out_valid_q;
    assign OUT_ID        = out_id_q;
    assign OUT_TIMESTAMP = out_ts_q;
    assign OUT_TOT       = out_tot_q;
    assign REC_CNT       = rec_cnt_q;

endmodule

// File: tb/tb_timestamp_div_word_decoder.sv
// Bench for timestamp_div_word_decoder: a queue models the upstream FWFT FIFO,
// a second queue holds the records the decoder should produce.
module tb_timestamp_div_word_decoder;

    typedef struct packed {
        logic [3:0]  id;
        logic [55:0] ts;
        logic [15:0] tot;
    } rec_t;

    logic        BUS_CLK;
    logic        BUS_RST;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic        FIFO_READ;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [3:0]  OUT_ID;
    logic [55:0] OUT_TIMESTAMP;
    logic [15:0] OUT_TOT;
    logic        CLR_CNT;
    logic [15:0] REC_CNT;
    logic [7:0]  SEQ_ERR_CNT;
    logic [7:0]  ID_ERR_CNT;

    logic [31:0] word_q[$];
    rec_t        exp_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic        rst_next     = 1'b1;
    logic        ready_next   = 1'b1;
    logic        clr_req      = 1'b0;
    logic        read_seen    = 1'b0;

    timestamp_div_word_decoder #(
        .IDENTIFIER (4'b0001),
        .CHECK_ID   (1'b1)
    ) dut (
        .BUS_CLK       (BUS_CLK),
        .BUS_RST       (BUS_RST),
        .FIFO_EMPTY    (FIFO_EMPTY),
        .FIFO_DATA     (FIFO_DATA),
        .FIFO_READ     (FIFO_READ),
        .OUT_VALID     (OUT_VALID),
        .OUT_READY     (OUT_READY),
        .OUT_ID        (OUT_ID),
        .OUT_TIMESTAMP (OUT_TIMESTAMP),
        .OUT_TOT       (OUT_TOT),
        .CLR_CNT       (CLR_CNT),
        .REC_CNT       (REC_CNT),
        .SEQ_ERR_CNT   (SEQ_ERR_CNT),
        .ID_ERR_CNT    (ID_ERR_CNT)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] w_hi(input logic [3:0] id, input logic [55:0] ts, input logic [15:0] tot);
        return {id, 4'h3, tot, ts[55:48]};
    endfunction

    function automatic logic [31:0] w_mid(input logic [3:0] id, input logic [55:0] ts);
        return {id, 4'h2, ts[47:24]};
    endfunction

    function automatic logic [31:0] w_lo(input logic [3:0] id, input logic [55:0] ts);
        return {id, 4'h1, ts[23:0]};
    endfunction

    task automatic push_triple(input logic [3:0] id, input logic [55:0] ts, input logic [15:0] tot, input bit expect_rec);
        rec_t r;
        word_q.push_back(w_hi(id, ts, tot));
        word_q.push_back(w_mid(id, ts));
        word_q.push_back(w_lo(id, ts));
        if (expect_rec) begin
            r.id  = id;
            r.ts  = ts;
            r.tot = tot;
            exp_q.push_back(r);
        end
    endtask

    task automatic push_exp(input logic [3:0] id, input logic [55:0] ts, input logic [15:0] tot);
        rec_t r;
        r.id  = id;
        r.ts  = ts;
        r.tot = tot;
        exp_q.push_back(r);
    endtask

    // Compare a presented record against the scoreboard head; pop it on handshake
    task automatic checkOutput();
        if (OUT_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_record", 64'(OUT_VALID), 64'(1'b0));
            end else begin
                check("out_id", 64'(OUT_ID), 64'(exp_q[0].id));
                check("out_timestamp", 64'(OUT_TIMESTAMP), 64'(exp_q[0].ts));
                check("out_tot", 64'(OUT_TOT), 64'(exp_q[0].tot));
                if (OUT_READY === 1'b1) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    endtask

    // One clock cycle: drive inputs after negedge, check, and pop the FIFO model on a read
    task automatic applyStimulus();
        @(negedge BUS_CLK);
        BUS_RST   = rst_next;
        OUT_READY = ready_next;
        CLR_CNT   = clr_req;
        clr_req   = 1'b0;
        if (word_q.size() > 0) begin
            FIFO_EMPTY = 1'b0;
            FIFO_DATA  = word_q[0];
        end else begin
            FIFO_EMPTY = 1'b1;
            FIFO_DATA  = 32'd0;
        end
        #1;
        checkOutput();
        read_seen = FIFO_READ;
        if ((FIFO_READ === 1'b1) && (word_q.size() > 0)) begin
            void'(word_q.pop_front());
        end
    endtask

    task automatic drain(input int limit);
        ready_next = 1'b1;
        for (int i = 0; (i < limit) && ((word_q.size() > 0) || (exp_q.size() > 0)); i++) begin
            applyStimulus();
        end
        applyStimulus();
        applyStimulus();
        check("drain_pending_words", 64'(word_q.size()), 64'd0);
        check("drain_pending_records", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_counters(input string tag, input int rec, input int seq, input int ide);
        check({tag, "_rec_cnt"}, 64'(REC_CNT), 64'(rec));
        check({tag, "_seq_err_cnt"}, 64'(SEQ_ERR_CNT), 64'(seq));
        check({tag, "_id_err_cnt"}, 64'(ID_ERR_CNT), 64'(ide));
    endtask

    initial begin
        logic [63:0] rnd;
        logic [55:0] ts;
        logic [31:0] foreign;

        BUS_RST    = 1'b1;
        OUT_READY  = 1'b1;
        CLR_CNT    = 1'b0;
        FIFO_EMPTY = 1'b1;
        FIFO_DATA  = 32'd0;

        // Reset with a record already waiting upstream: nothing may be read
        word_q.push_back(32'h13ABCD12);
        word_q.push_back(32'h12345678);
        word_q.push_back(32'h119ABCDE);
        push_exp(4'h1, 56'h123456789ABCDE, 16'hABCD);
        rst_next = 1'b1;
        applyStimulus();
        applyStimulus();
        check("reset_out_valid", 64'(OUT_VALID), 64'd0);
        check("reset_out_id", 64'(OUT_ID), 64'd0);
        check("reset_out_timestamp", 64'(OUT_TIMESTAMP), 64'd0);
        check("reset_out_tot", 64'(OUT_TOT), 64'd0);
        check("reset_fifo_read", 64'(read_seen), 64'd0);
        check_counters("reset", 0, 0, 0);

        // Single record with its emit latency
        rst_next = 1'b0;
        applyStimulus();
        check("single_read_w3", 64'(read_seen), 64'd1);
        applyStimulus();
        applyStimulus();
        check("single_valid_before_emit", 64'(OUT_VALID), 64'd0);
        applyStimulus();
        check("single_valid_after_emit", 64'(OUT_VALID), 64'd1);
        check("single_delivered", 64'(exp_q.size()), 64'd0);
        check_counters("single", 1, 0, 0);
        applyStimulus();
        check("single_valid_clears", 64'(OUT_VALID), 64'd0);

        // 100 back-to-back records: upstream read every cycle
        for (int i = 0; i < 100; i++) begin
            rnd = {$urandom(), $urandom()};
            ts  = rnd[55:0];
            push_triple(4'h1, ts, 16'($urandom()), 1'b1);
        end
        for (int i = 0; (i < 400) && (word_q.size() > 0); i++) begin
            applyStimulus();
            check("b2b_fifo_read", 64'(read_seen), 64'd1);
        end
        drain(50);
        check_counters("b2b", 101, 0, 0);

        // Downstream stall with two records queued
        ready_next = 1'b0;
        push_triple(4'h1, 56'hA1A2A3A4A5A6A7, 16'h1111, 1'b1);
        push_triple(4'h1, 56'hB1B2B3B4B5B6B7, 16'h2222, 1'b1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            if (i >= 3) begin
                check("stall_fifo_read", 64'(read_seen), 64'd0);
            end
        end
        check("stall_words_left", 64'(word_q.size()), 64'd3);
        check("stall_valid_held", 64'(OUT_VALID), 64'd1);
        drain(50);
        check_counters("stall", 103, 0, 0);

        // Orphan word 3 then word 1: one sequence error, next triple intact
        word_q.push_back(32'h13000001);
        word_q.push_back(32'h11000002);
        push_triple(4'h1, 56'h0102030405060A, 16'h5A5A, 1'b1);
        drain(50);
        check_counters("seq_orphan", 104, 1, 0);

        // Second word 3 restarts the record
        word_q.push_back(32'h13AAAA11);
        word_q.push_back(32'h12222222);
        word_q.push_back(32'h13BBBB33);
        word_q.push_back(32'h12444444);
        word_q.push_back(32'h11555555);
        push_exp(4'h1, 56'h33444444555555, 16'hBBBB);
        drain(50);
        check_counters("seq_restart", 105, 2, 0);

        // Unknown type nibble discards the partial record
        word_q.push_back(32'h13CCCC44);
        word_q.push_back(32'h10000000);
        push_triple(4'h1, 56'hFEDCBA98765432, 16'hC0DE, 1'b1);
        drain(50);
        check_counters("seq_type0", 106, 3, 0);

        // Foreign word inside a triple is dropped without breaking the record
        ts = 56'h0F1E2D3C4B5A69;
        word_q.push_back(w_hi(4'h1, ts, 16'h7788));
        word_q.push_back(32'h21000000);
        word_q.push_back(w_mid(4'h1, ts));
        word_q.push_back(w_lo(4'h1, ts));
        push_exp(4'h1, ts, 16'h7788);
        drain(50);
        check_counters("id_inside", 107, 3, 1);

        // 300 foreign words saturate the ID error counter
        for (int i = 0; i < 300; i++) begin
            foreign = $urandom();
            foreign[31:28] = (i % 2 == 0) ? 4'h2 : 4'hF;
            word_q.push_back(foreign);
        end
        drain(400);
        check_counters("id_saturate", 107, 3, 255);

        // Clear pulse coincides with another foreign word
        word_q.push_back(32'h2F000000);
        clr_req = 1'b1;
        applyStimulus();
        check("clr_fifo_read", 64'(read_seen), 64'd1);
        applyStimulus();
        check_counters("clear", 0, 0, 0);

        // Reset after words 3 and 2: partial record must be forgotten
        ready_next = 1'b1;
        ts = 56'h11223344556677;
        word_q.push_back(w_hi(4'h1, ts, 16'h9999));
        word_q.push_back(w_mid(4'h1, ts));
        applyStimulus();
        applyStimulus();
        applyStimulus();
        rst_next = 1'b1;
        applyStimulus();
        rst_next = 1'b0;
        applyStimulus();
        check("rst_partial_valid", 64'(OUT_VALID), 64'd0);
        word_q.push_back(w_lo(4'h1, ts));
        push_triple(4'h1, 56'h8899AABBCCDDEE, 16'h4321, 1'b1);
        drain(50);
        check_counters("rst_partial", 1, 1, 0);

        // Reset while a record is stalled: pending valid is dropped
        ready_next = 1'b0;
        push_triple(4'h1, 56'h0A0B0C0D0E0F10, 16'h6666, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
        end
        check("rst_pending_before", 64'(OUT_VALID), 64'd1);
        rst_next = 1'b1;
        applyStimulus();
        exp_q.delete();
        rst_next = 1'b0;
        applyStimulus();
        check("rst_pending_dropped", 64'(OUT_VALID), 64'd0);
        check_counters("rst_pending", 0, 0, 0);
        push_triple(4'h1, 56'h5566778899AABB, 16'hBEEF, 1'b1);
        drain(50);
        check_counters("post_reset", 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
